serial_transmitter: RTL and testbench

- Transmit end of the team's framed serial link; drives the `comEn`/data pair that the receive block samples.
- Accepts 32-bit words over a valid/ready handshake and buffers them in a small FIFO.
- Serializes each word MSB-first inside a frame of exactly DATA_WIDTH+2 cycles with `comEn` high, then holds `comEn` low for a programmable gap.
- Frame timing matches the receiver: 1 lead bit, DATA_WIDTH data bits, 1 ready cycle.

---
 rtl/serial_transmitter.sv | 175 +++++++++++++++++
 tb/tb_serial_transmitter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_transmitter.sv
// serial_transmitter: buffers words and sends each MSB-first inside a comEn frame of DATA_WIDTH+2 cycles.
// Latency: a word pushed into an empty FIFO at edge E raises comEn at E+1; then GAP_CYCLES low cycles between frames.
// Backpressure: tx_ready = (fifo_count != FIFO_DEPTH); a push while full is dropped with no state change.

// Small word FIFO; head is read combinationally so the FSM can load it on the pop edge.
module serial_transmitter_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_vld,
    input  logic [WIDTH-1:0]         wr_dat,
    output logic                     wr_rdy,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_dat,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push;
    logic             pop;

    assign wr_rdy = (count != FULL_CNT);
    assign push   = wr_vld && wr_rdy;
    assign pop    = rd_en && (count != '0);
    assign rd_dat = mem[rd_ptr];

    // Storage array; not reset, since pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    // Pointers wrap naturally (DEPTH is a power of two); count tracks occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end
endmodule

module serial_transmitter #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_CYCLES = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_WIDTH-1:0]         tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          dataout,
    output logic                          comEn,
    output logic                          frame_done,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, TAIL, GAP} state_t;

    state_t                state, state_n;
    logic [DATA_WIDTH-1:0] shreg, shreg_n;
    logic [CW-1:0]         bit_cnt, bit_cnt_n;
    logic [GW-1:0]         gap_cnt, gap_cnt_n;
    logic                  dataout_n, comEn_n, frame_done_n;
    logic                  pop;
    logic [DATA_WIDTH-1:0] head;

    serial_transmitter_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .wr_vld (tx_valid),
        .wr_dat (tx_data),
        .wr_rdy (tx_ready),
        .rd_en  (pop),
        .rd_dat (head),
        .count  (fifo_count)
    );

    assign busy = (state != IDLE) || (fifo_count != '0);

    // State and registered line outputs; reset drops comEn immediately, aborting any frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            dataout    <= 1'b0;
            comEn      <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            shreg      <= shreg_n;
            bit_cnt    <= bit_cnt_n;
            gap_cnt    <= gap_cnt_n;
            dataout    <= dataout_n;
            comEn      <= comEn_n;
            frame_done <= frame_done_n;
        end
    end

    // Next-state logic: lead bit, DATA_WIDTH data bits, one tail cycle, then the gap.
    always_comb begin
        state_n      = state;
        shreg_n      = shreg;
        bit_cnt_n    = bit_cnt;
        gap_cnt_n    = gap_cnt;
        dataout_n    = 1'b0;
        comEn_n      = 1'b0;
        frame_done_n = 1'b0;
        pop          = 1'b0;
        case (state)
            IDLE: begin
                if (fifo_count != '0) begin
                    pop       = 1'b1;
                    shreg_n   = head;
                    comEn_n   = 1'b1;
                    bit_cnt_n = '0;
                    state_n   = SHIFT;
                end
            end
            SHIFT: begin
                comEn_n = 1'b1;
                if (bit_cnt == CW'(DATA_WIDTH)) begin
                    // LSB has been on the line for a cycle; next cycle is the receiver's ready cycle.
                    state_n = TAIL;
                end else begin
                    dataout_n = shreg[DATA_WIDTH-1];
                    shreg_n   = {shreg[DATA_WIDTH-2:0], 1'b0};
                    bit_cnt_n = bit_cnt + 1'b1;
                end
            end
            TAIL: begin
                frame_done_n = 1'b1;
                gap_cnt_n    = GW'(1);
                state_n      = GAP;
            end
            GAP: begin
                if (gap_cnt == GW'(GAP_CYCLES)) begin
                    if (fifo_count != '0) begin
                        pop       = 1'b1;
                        shreg_n   = head;
                        comEn_n   = 1'b1;
                        bit_cnt_n = '0;
                        state_n   = SHIFT;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    gap_cnt_n = gap_cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_serial_transmitter.sv
// Bench for serial_transmitter: two instances (gap 1 and gap 3) with a receiver-style frame monitor.
// Directed stimulus per scenario; expected words, lengths and gaps are hand-computed constants.
// Every wait is bounded by a cycle budget so the run always reaches the summary line.
module tb_serial_transmitter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [31:0] tx_data0, tx_data1;
    logic        tx_valid0, tx_valid1;
    logic        tx_ready0, tx_ready1;
    logic        dataout0, dataout1;
    logic        comEn0, comEn1;
    logic        frame_done0, frame_done1;
    logic        busy0, busy1;
    logic [2:0]  fifo_count0, fifo_count1;

    int checks = 0;
    int failures = 0;

    serial_transmitter #(.DATA_WIDTH(32), .FIFO_DEPTH(4), .GAP_CYCLES(1)) dut0 (
        .clk(clk), .reset(reset), .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_ready(tx_ready0),
        .dataout(dataout0), .comEn(comEn0), .frame_done(frame_done0), .busy(busy0), .fifo_count(fifo_count0)
    );

    serial_transmitter #(.DATA_WIDTH(32), .FIFO_DEPTH(4), .GAP_CYCLES(3)) dut1 (
        .clk(clk), .reset(reset), .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready1),
        .dataout(dataout1), .comEn(comEn1), .frame_done(frame_done1), .busy(busy1), .fifo_count(fifo_count1)
    );

    // Receiver model: frames recorded per channel (word, length, lead bit, tail bit, low cycles before it).
    logic [31:0] mw    [2][32];
    int          ml    [2][32];
    logic        mlead [2][32];
    logic        mtail [2][32];
    int          mgap  [2][32];
    int          nfr   [2] = '{0, 0};
    int          fdc   [2] = '{0, 0};
    int          hl    [2] = '{0, 0};
    int          low   [2] = '{0, 0};
    int          pgap  [2] = '{0, 0};
    logic        in_fr [2] = '{1'b0, 1'b0};
    logic        havep [2] = '{1'b0, 1'b0};
    logic        ld    [2] = '{1'b0, 1'b0};
    logic        tl    [2] = '{1'b0, 1'b0};
    logic [31:0] acc   [2] = '{32'h0, 32'h0};

    always @(negedge clk) begin
        logic en [2];
        logic d  [2];
        logic fd [2];
        en[0] = comEn0;      en[1] = comEn1;
        d[0]  = dataout0;    d[1]  = dataout1;
        fd[0] = frame_done0; fd[1] = frame_done1;
        for (int c = 0; c < 2; c++) begin
            if (reset) begin
                in_fr[c] = 1'b0;
                havep[c] = 1'b0;
            end else begin
                if (fd[c]) fdc[c] = fdc[c] + 1;
                if (en[c]) begin
                    if (!in_fr[c]) begin
                        in_fr[c] = 1'b1;
                        hl[c]    = 1;
                        ld[c]    = d[c];
                        acc[c]   = 32'h0;
                        tl[c]    = 1'b0;
                        pgap[c]  = havep[c] ? low[c] : -1;
                    end else begin
                        hl[c] = hl[c] + 1;
                        if (hl[c] <= 33) acc[c] = {acc[c][30:0], d[c]};
                        else             tl[c]  = d[c];
                    end
                end else if (in_fr[c]) begin
                    if (nfr[c] < 32) begin
                        mw[c][nfr[c]]    = acc[c];
                        ml[c][nfr[c]]    = hl[c];
                        mlead[c][nfr[c]] = ld[c];
                        mtail[c][nfr[c]] = tl[c];
                        mgap[c][nfr[c]]  = pgap[c];
                    end
                    nfr[c]   = nfr[c] + 1;
                    in_fr[c] = 1'b0;
                    havep[c] = 1'b1;
                    low[c]   = 1;
                end else if (havep[c]) begin
                    low[c] = low[c] + 1;
                end
            end
        end
    end

    // Called at a negedge; presents one word for exactly one rising edge.
    task automatic push0(input logic [31:0] w);
        tx_data0 = w; tx_valid0 = 1'b1;
        @(negedge clk);
        tx_valid0 = 1'b0;
    endtask

    task automatic push1(input logic [31:0] w);
        tx_data1 = w; tx_valid1 = 1'b1;
        @(negedge clk);
        tx_valid1 = 1'b0;
    endtask

    task automatic wait_idle(input int c, input int budget);
        int n;
        n = 0;
        while ((c == 0 ? busy0 : busy1) && n < budget) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tx_valid0 = 1'b0; tx_valid1 = 1'b0; tx_data0 = '0; tx_data1 = '0;
        repeat (2) @(negedge clk);
        checks++; if (dataout0 !== 1'b0)    begin failures++; $display("FAIL rst_dataout: got %b want 0", dataout0); end
        checks++; if (comEn0 !== 1'b0)      begin failures++; $display("FAIL rst_comEn: got %b want 0", comEn0); end
        checks++; if (frame_done0 !== 1'b0) begin failures++; $display("FAIL rst_frame_done: got %b want 0", frame_done0); end
        checks++; if (busy0 !== 1'b0)       begin failures++; $display("FAIL rst_busy: got %b want 0", busy0); end
        checks++; if (fifo_count0 !== 3'd0) begin failures++; $display("FAIL rst_fifo_count: got %0d want 0", fifo_count0); end
        checks++; if (tx_ready0 !== 1'b1)   begin failures++; $display("FAIL rst_tx_ready: got %b want 1", tx_ready0); end
        checks++; if (comEn1 !== 1'b0)      begin failures++; $display("FAIL rst_comEn_gap3: got %b want 0", comEn1); end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single;
        int b, f;
        b = nfr[0]; f = fdc[0];
        push0(32'hA5A50F0F);
        checks++; if (comEn0 !== 1'b0)      begin failures++; $display("FAIL single_comEn_at_push: got %b want 0", comEn0); end
        checks++; if (fifo_count0 !== 3'd1) begin failures++; $display("FAIL single_count_after_push: got %0d want 1", fifo_count0); end
        checks++; if (busy0 !== 1'b1)       begin failures++; $display("FAIL single_busy: got %b want 1", busy0); end
        @(negedge clk);
        checks++; if (comEn0 !== 1'b1)      begin failures++; $display("FAIL single_comEn_rise: got %b want 1", comEn0); end
        checks++; if (dataout0 !== 1'b0)    begin failures++; $display("FAIL single_lead: got %b want 0", dataout0); end
        checks++; if (fifo_count0 !== 3'd0) begin failures++; $display("FAIL single_count_after_pop: got %0d want 0", fifo_count0); end
        @(negedge clk);
        checks++; if (dataout0 !== 1'b1)    begin failures++; $display("FAIL single_msb: got %b want 1", dataout0); end
        wait_idle(0, 200);
        checks++; if (nfr[0] - b !== 1) begin failures++; $display("FAIL single_frames: got %0d want 1", nfr[0] - b); end
        checks++; if (mw[0][b] !== 32'hA5A50F0F) begin failures++; $display("FAIL single_word: got %h want a5a50f0f", mw[0][b]); end
        checks++; if (ml[0][b] !== 34)   begin failures++; $display("FAIL single_len: got %0d want 34", ml[0][b]); end
        checks++; if (mlead[0][b] !== 1'b0 || mtail[0][b] !== 1'b0) begin failures++; $display("FAIL single_lead_tail: got %b%b want 00", mlead[0][b], mtail[0][b]); end
        checks++; if (fdc[0] - f !== 1)  begin failures++; $display("FAIL single_frame_done: got %0d pulses want 1", fdc[0] - f); end
    endtask

    task automatic test_four;
        logic [31:0] exp [4];
        int b, f;
        exp[0] = 32'h00000001; exp[1] = 32'h80000000; exp[2] = 32'hFFFFFFFF; exp[3] = 32'h00000000;
        b = nfr[0]; f = fdc[0];
        for (int i = 0; i < 4; i++) push0(exp[i]);
        // The first word is popped one edge after its push, so three remain.
        checks++; if (fifo_count0 !== 3'd3) begin failures++; $display("FAIL four_count: got %0d want 3", fifo_count0); end
        checks++; if (tx_ready0 !== 1'b1)   begin failures++; $display("FAIL four_ready: got %b want 1", tx_ready0); end
        wait_idle(0, 400);
        checks++; if (nfr[0] - b !== 4) begin failures++; $display("FAIL four_frames: got %0d want 4", nfr[0] - b); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (mw[0][b+i] !== exp[i]) begin failures++; $display("FAIL four_word[%0d]: got %h want %h", i, mw[0][b+i], exp[i]); end
            checks++; if (ml[0][b+i] !== 34)     begin failures++; $display("FAIL four_len[%0d]: got %0d want 34", i, ml[0][b+i]); end
            if (i > 0) begin
                checks++; if (mgap[0][b+i] !== 1) begin failures++; $display("FAIL four_gap[%0d]: got %0d want 1", i, mgap[0][b+i]); end
            end
        end
        checks++; if (fdc[0] - f !== 4) begin failures++; $display("FAIL four_frame_done: got %0d want 4", fdc[0] - f); end
    endtask

    task automatic test_overflow;
        logic [31:0] exp [5];
        int b, n;
        exp[0] = 32'h11111111; exp[1] = 32'h22222222; exp[2] = 32'h33333333;
        exp[3] = 32'h44444444; exp[4] = 32'h55555555;
        b = nfr[0];
        for (int i = 0; i < 5; i++) push0(exp[i]);
        checks++; if (fifo_count0 !== 3'd4) begin failures++; $display("FAIL ovf_count_full: got %0d want 4", fifo_count0); end
        checks++; if (tx_ready0 !== 1'b0)   begin failures++; $display("FAIL ovf_ready_full: got %b want 0", tx_ready0); end
        push0(32'hDEADBEEF);
        checks++; if (fifo_count0 !== 3'd4) begin failures++; $display("FAIL ovf_count_after_drop: got %0d want 4", fifo_count0); end
        // First frame popped 4 edges ago; its gap pop lands 31 edges from here.
        n = 0;
        while (!tx_ready0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++; if (n !== 31) begin failures++; $display("FAIL ovf_ready_return: got %0d cycles want 31", n); end
        wait_idle(0, 400);
        checks++; if (nfr[0] - b !== 5) begin failures++; $display("FAIL ovf_frames: got %0d want 5", nfr[0] - b); end
        for (int i = 0; i < 5; i++) begin
            checks++; if (mw[0][b+i] !== exp[i]) begin failures++; $display("FAIL ovf_word[%0d]: got %h want %h", i, mw[0][b+i], exp[i]); end
        end
    endtask

    task automatic test_reset_mid;
        int b;
        b = nfr[0];
        push0(32'hFFFFFFFF);
        push0(32'h0000FFFF);
        repeat (9) @(negedge clk);
        checks++; if (comEn0 !== 1'b1 || dataout0 !== 1'b1) begin failures++; $display("FAIL rmid_pre: got comEn=%b dataout=%b want 1 1", comEn0, dataout0); end
        #2 reset = 1'b1;
        #1;
        checks++; if (comEn0 !== 1'b0)      begin failures++; $display("FAIL rmid_comEn_async: got %b want 0", comEn0); end
        checks++; if (dataout0 !== 1'b0)    begin failures++; $display("FAIL rmid_dataout_async: got %b want 0", dataout0); end
        checks++; if (fifo_count0 !== 3'd0) begin failures++; $display("FAIL rmid_count: got %0d want 0", fifo_count0); end
        checks++; if (tx_ready0 !== 1'b1)   begin failures++; $display("FAIL rmid_ready: got %b want 1", tx_ready0); end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (nfr[0] !== b) begin failures++; $display("FAIL rmid_partial: got %0d frames want %0d", nfr[0], b); end
        push0(32'h12345678);
        wait_idle(0, 200);
        checks++; if (nfr[0] - b !== 1) begin failures++; $display("FAIL rmid_frames: got %0d want 1", nfr[0] - b); end
        checks++; if (mw[0][b] !== 32'h12345678) begin failures++; $display("FAIL rmid_word: got %h want 12345678", mw[0][b]); end
        checks++; if (ml[0][b] !== 34) begin failures++; $display("FAIL rmid_len: got %0d want 34", ml[0][b]); end
    endtask

    task automatic test_gap3;
        int b, f;
        b = nfr[1]; f = fdc[1];
        push1(32'h0F0F0F0F);
        push1(32'hC3C3C3C3);
        wait_idle(1, 400);
        checks++; if (nfr[1] - b !== 2) begin failures++; $display("FAIL gap3_frames: got %0d want 2", nfr[1] - b); end
        checks++; if (mw[1][b] !== 32'h0F0F0F0F)   begin failures++; $display("FAIL gap3_word0: got %h want 0f0f0f0f", mw[1][b]); end
        checks++; if (mw[1][b+1] !== 32'hC3C3C3C3) begin failures++; $display("FAIL gap3_word1: got %h want c3c3c3c3", mw[1][b+1]); end
        checks++; if (ml[1][b] !== 34 || ml[1][b+1] !== 34) begin failures++; $display("FAIL gap3_len: got %0d,%0d want 34,34", ml[1][b], ml[1][b+1]); end
        checks++; if (mgap[1][b+1] !== 3) begin failures++; $display("FAIL gap3_gap: got %0d want 3", mgap[1][b+1]); end
        checks++; if (fdc[1] - f !== 2)   begin failures++; $display("FAIL gap3_frame_done: got %0d want 2", fdc[1] - f); end
    endtask

    task automatic test_midshift;
        int b;
        b = nfr[0];
        push0(32'h13579BDF);
        repeat (15) @(negedge clk);
        checks++; if (comEn0 !== 1'b1) begin failures++; $display("FAIL mid_active: got %b want 1", comEn0); end
        push0(32'h2468ACE0);
        wait_idle(0, 300);
        checks++; if (nfr[0] - b !== 2) begin failures++; $display("FAIL mid_frames: got %0d want 2", nfr[0] - b); end
        checks++; if (mw[0][b] !== 32'h13579BDF)   begin failures++; $display("FAIL mid_word0: got %h want 13579bdf", mw[0][b]); end
        checks++; if (mw[0][b+1] !== 32'h2468ACE0) begin failures++; $display("FAIL mid_word1: got %h want 2468ace0", mw[0][b+1]); end
        checks++; if (ml[0][b] !== 34)   begin failures++; $display("FAIL mid_len: got %0d want 34", ml[0][b]); end
        checks++; if (mgap[0][b+1] !== 1) begin failures++; $display("FAIL mid_gap: got %0d want 1", mgap[0][b+1]); end
    endtask

    initial begin
        test_reset;
        test_single;
        test_four;
        test_overflow;
        test_reset_mid;
        test_gap3;
        test_midshift;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
